dram_line_fetcher: RTL and testbench

- Scanout-side stage between the SDRAM controller read port and the on-chip dual-port line buffer (port B).
- On a START request, issues pipelined reads for one framebuffer line from SDRAM and writes the returned words in order into one half (ping-pong bank) of the line buffer.
- The VGA scanout reads the line buffer on the other port.
- Reports BUSY and a one-cycle DONE pulse per line.

---
 rtl/dram_line_fetcher_if.sv | 22 ++
 rtl/dram_line_fetcher.sv | 149 ++++++++++++++
 tb/tb_dram_line_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_line_fetcher_if.sv
// SDRAM read port plus line-buffer port B, bundled as seen from the line fetcher.
interface dram_line_fetcher_if;
    logic [24:0] DRAM_ADDRESS;
    logic        DRAM_READ_N;
    logic        DRAM_WRITE_N;
    logic        DRAM_WAITREQUEST;
    logic [15:0] DRAM_READDATA;
    logic        DRAM_READDATAVALID;
    logic [15:0] OCM_ADDR;
    logic [15:0] OCM_DATA;
    logic        OCM_WE;

    modport master (
        output DRAM_ADDRESS, DRAM_READ_N, DRAM_WRITE_N, OCM_ADDR, OCM_DATA, OCM_WE,
        input  DRAM_WAITREQUEST, DRAM_READDATA, DRAM_READDATAVALID
    );

    modport slave (
        input  DRAM_ADDRESS, DRAM_READ_N, DRAM_WRITE_N, OCM_ADDR, OCM_DATA, OCM_WE,
        output DRAM_WAITREQUEST, DRAM_READDATA, DRAM_READDATAVALID
    );
endinterface

// File: rtl/dram_line_fetcher.sv
// Fetches one framebuffer line from SDRAM into a ping-pong line-buffer bank; each return is written 1 cycle later.
// Reads stall under DRAM_WAITREQUEST and stop at MAX_OUTSTANDING in flight; DONE pulses 1 cycle after the last write.
module dram_line_fetcher #(
    parameter int unsigned LINE_WORDS      = 640,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [24:0] FB_BASE         = 25'd0,
    parameter logic [15:0] OCM_BASE        = 16'd0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       START,
    input  logic [9:0]                 LINE,
    input  logic                       BANK,
    output logic                       BUSY,
    output logic                       DONE,
    dram_line_fetcher_if.master        bus
);
    localparam int          CW      = 16;
    localparam int          OW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] LW      = CW'(LINE_WORDS);
    localparam logic [CW-1:0] LW_LAST = CW'(LINE_WORDS - 1);
    localparam logic [24:0] LW_25   = 25'(LINE_WORDS);
    localparam logic [OW-1:0] MAXO    = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] ONE_O   = OW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [24:0]     base_q, base_d;
    logic            bank_q, bank_d;
    logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]   recv_cnt_q, recv_cnt_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            rd_n_q, rd_n_d;
    logic [24:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [15:0]     oaddr_q, oaddr_d;
    logic [15:0]     odata_q, odata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic accept;
    logic rdv_ok;

    assign accept = !rd_n_q && !bus.DRAM_WAITREQUEST;
    // Returns outside a fetch are leftovers from before a reset and must not reach the line buffer.
    assign rdv_ok = bus.DRAM_READDATAVALID && (state_q == S_ISSUE || state_q == S_DRAIN);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        bank_d      = bank_q;
        issue_cnt_d = issue_cnt_q + CW'(accept);
        recv_cnt_d  = recv_cnt_q + CW'(rdv_ok);
        outst_d     = outst_q;
        rd_n_d      = 1'b1;
        addr_d      = addr_q;
        we_d        = rdv_ok;
        oaddr_d     = oaddr_q;
        odata_d     = odata_q;

        if (accept && !rdv_ok) begin
            outst_d = outst_q + ONE_O;
        end else if (!accept && rdv_ok) begin
            outst_d = outst_q - ONE_O;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (START) begin
                    state_d     = S_ISSUE;
                    base_d      = FB_BASE + 25'(LINE) * LW_25;
                    bank_d      = BANK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            S_ISSUE: begin
                if (accept && issue_cnt_q == LW_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (we_q && recv_cnt_q == LW) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled request keeps its address; otherwise issue whenever budget allows.
        if (!rd_n_q && bus.DRAM_WAITREQUEST) begin
            rd_n_d = 1'b0;
        end else if (state_d == S_ISSUE && issue_cnt_d < LW && outst_d < MAXO) begin
            rd_n_d = 1'b0;
            addr_d = base_d + 25'(issue_cnt_d);
        end

        if (rdv_ok) begin
            odata_d = bus.DRAM_READDATA;
            oaddr_d = OCM_BASE + (bank_q ? LW : 16'd0) + recv_cnt_q;
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            bank_q      <= 1'b0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            outst_q     <= '0;
            rd_n_q      <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            oaddr_q     <= '0;
            odata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            bank_q      <= bank_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            outst_q     <= outst_d;
            rd_n_q      <= rd_n_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            oaddr_q     <= oaddr_d;
            odata_q     <= odata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign BUSY             = busy_q;
    assign DONE             = done_q;
    assign bus.DRAM_ADDRESS = addr_q;
    assign bus.DRAM_READ_N  = rd_n_q;
    assign bus.DRAM_WRITE_N = 1'b1;
    assign bus.OCM_ADDR     = oaddr_q;
    assign bus.OCM_DATA     = odata_q;
    assign bus.OCM_WE       = we_q;
endmodule

// File: tb/tb_dram_line_fetcher.sv
// Randomised line fetches against an SDRAM model with variable latency and stalls; scoreboard checks every read and write.
module tb_dram_line_fetcher;
    localparam int          LW   = 640;
    localparam int          MAXO = 8;
    localparam logic [24:0] FBB  = 25'h1FF_0000;
    localparam logic [15:0] OCB  = 16'hFC00;

    logic       CLK;
    logic       RESET_N;
    logic       START;
    logic [9:0] LINE;
    logic       BANK;
    logic       BUSY;
    logic       DONE;

    dram_line_fetcher_if bus();

    dram_line_fetcher #(
        .LINE_WORDS(LW), .MAX_OUTSTANDING(MAXO), .FB_BASE(FBB), .OCM_BASE(OCB)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .LINE(LINE), .BANK(BANK),
        .BUSY(BUSY), .DONE(DONE), .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct { logic [15:0] a; logic [15:0] d; bit last; } wr_t;
    typedef struct { logic [24:0] a; int due; int gen; } pend_t;

    logic [24:0] exp_rd[$];
    wr_t         exp_wr[$];
    pend_t       pend[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gen = 0;
    int flush_cnt = 0;
    int rdv_gen = 0;
    int lat = 3;
    int jit = 0;
    int stall_pct = 0;

    function automatic logic [15:0] dram_word(input logic [24:0] a);
        int v;
        v = (int'(a) * 3 + 7) % 65536;
        return 16'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push_line(input int ln, input bit bk, output logic [24:0] base);
        base = 25'((int'(FBB) + ln * LW) % 33554432);
        for (int i = 0; i < LW; i++) begin
            wr_t w;
            int  ra;
            int  oa;
            ra = (int'(FBB) + ln * LW + i) % 33554432;
            oa = (int'(OCB) + (bk ? LW : 0) + i) % 65536;
            exp_rd.push_back(25'(ra));
            w.a = 16'(oa);
            w.d = dram_word(25'(ra));
            w.last = (i == LW - 1);
            exp_wr.push_back(w);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, BUSY, 0);
        chk({nm, "_done"}, DONE, 0);
        chk({nm, "_read_n"}, bus.DRAM_READ_N, 1);
        chk({nm, "_write_n"}, bus.DRAM_WRITE_N, 1);
        chk({nm, "_dram_addr"}, bus.DRAM_ADDRESS, 0);
        chk({nm, "_ocm_we"}, bus.OCM_WE, 0);
        chk({nm, "_ocm_addr"}, bus.OCM_ADDR, 0);
        chk({nm, "_ocm_data"}, bus.OCM_DATA, 0);
    endtask

    task automatic wait_done(input string nm, input bit check_empty);
        int n;
        n = 0;
        while (DONE !== 1'b1 && n < 8000) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_done_seen"}, DONE, 1);
        if (check_empty) chk({nm, "_words_left"}, exp_wr.size() + exp_rd.size(), 0);
    endtask

    task automatic run_line(input string nm, input int ln, input bit bk, input bit spurious);
        logic [24:0] b;
        @(posedge CLK);
        #1;
        START = 1'b1;
        LINE = 10'(ln);
        BANK = bk;
        push_line(ln, bk, b);
        @(posedge CLK);
        #1;
        START = 1'b0;
        LINE = 10'($urandom);
        BANK = 1'($urandom);
        @(negedge CLK);
        chk({nm, "_busy_after_start"}, BUSY, 1);
        chk({nm, "_first_read_n"}, bus.DRAM_READ_N, 0);
        chk({nm, "_first_addr"}, bus.DRAM_ADDRESS, b);
        if (spurious) begin
            repeat (20) @(posedge CLK);
            #1;
            START = 1'b1;
            LINE = 10'($urandom);
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        wait_done(nm, 1);
    endtask

    // SDRAM model: in-order returns, per-request latency, random stall bursts.
    initial begin : dram_model
        int    stall_left;
        pend_t p;
        stall_left = 0;
        bus.DRAM_WAITREQUEST = 1'b0;
        bus.DRAM_READDATAVALID = 1'b0;
        bus.DRAM_READDATA = 16'd0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (bus.DRAM_READ_N === 1'b0 && bus.DRAM_WAITREQUEST === 1'b0) begin
                p.a = bus.DRAM_ADDRESS;
                p.gen = gen;
                p.due = cyc + lat + int'($urandom_range(jit, 0));
                if (pend.size() > 0 && p.due <= pend[$].due) p.due = pend[$].due + 1;
                pend.push_back(p);
            end
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.DRAM_READDATAVALID = 1'b1;
                bus.DRAM_READDATA = dram_word(pend[0].a);
                rdv_gen = pend[0].gen;
                void'(pend.pop_front());
            end else begin
                bus.DRAM_READDATAVALID = 1'b0;
                bus.DRAM_READDATA = 16'($urandom);
            end
            if (stall_left > 0) begin
                bus.DRAM_WAITREQUEST = 1'b1;
                stall_left--;
            end else if (int'($urandom_range(99, 0)) < stall_pct) begin
                bus.DRAM_WAITREQUEST = 1'b1;
                stall_left = int'($urandom_range(5, 0));
            end else begin
                bus.DRAM_WAITREQUEST = 1'b0;
            end
        end
    end

    initial begin : monitor
        int          mo;
        int          seen_flush;
        bit          prev_last;
        bit          cur_last;
        bit          prev_stall;
        bit          acc;
        logic [24:0] prev_addr;
        wr_t         w;
        mo = 0;
        seen_flush = 0;
        prev_last = 0;
        prev_stall = 0;
        prev_addr = '0;
        forever begin
            @(negedge CLK);
            if (seen_flush != flush_cnt) begin
                seen_flush = flush_cnt;
                exp_rd.delete();
                exp_wr.delete();
                mo = 0;
                prev_last = 0;
                prev_stall = 0;
            end
            acc = (bus.DRAM_READ_N === 1'b0) && (bus.DRAM_WAITREQUEST === 1'b0);
            if (prev_stall) begin
                chk("stall_hold_read_n", bus.DRAM_READ_N, 0);
                chk("stall_hold_addr", bus.DRAM_ADDRESS, prev_addr);
            end
            if (bus.DRAM_READ_N === 1'b0) chk("outstanding_below_max", (mo < MAXO), 1);
            if (acc) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: addr %0h, no read required", bus.DRAM_ADDRESS);
                end else begin
                    chk("read_addr", bus.DRAM_ADDRESS, exp_rd.pop_front());
                end
            end
            cur_last = 0;
            if (bus.OCM_WE === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write required",
                             bus.OCM_ADDR, bus.OCM_DATA);
                end else begin
                    w = exp_wr.pop_front();
                    chk("ocm_addr", bus.OCM_ADDR, w.a);
                    chk("ocm_data", bus.OCM_DATA, w.d);
                    chk("write_n_const", bus.DRAM_WRITE_N, 1);
                    cur_last = w.last;
                end
            end
            if (DONE === 1'b1 || prev_last) begin
                chk("done_timing", DONE, prev_last);
                if (DONE === 1'b1) chk("busy_low_in_done", BUSY, 0);
            end
            if (acc) mo++;
            if (bus.DRAM_READDATAVALID === 1'b1 && rdv_gen == gen) mo--;
            prev_last = cur_last;
            prev_stall = (bus.DRAM_READ_N === 1'b0) && (bus.DRAM_WAITREQUEST === 1'b1);
            prev_addr = bus.DRAM_ADDRESS;
        end
    end

    initial begin : stim
        logic [24:0] b1;
        logic [24:0] b2;
        int          n;
        RESET_N = 1'b0;
        START = 1'b0;
        LINE = '0;
        BANK = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset("reset");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        lat = 3; jit = 0; stall_pct = 0;
        run_line("line2_bank1", 2, 1'b1, 1'b0);

        for (int k = 0; k < 5; k++) begin
            lat = int'($urandom_range(22, 0));
            jit = int'($urandom_range(3, 0));
            stall_pct = int'($urandom_range(15, 0));
            run_line("rand_line", int'($urandom_range(1023, 0)), 1'($urandom), k[0]);
        end

        lat = 20; jit = 0; stall_pct = 10;
        run_line("wrap_line", 1023, 1'b1, 1'b1);

        // START held high through DONE chains a second line with no idle cycle.
        lat = 6; jit = 2; stall_pct = 5;
        @(posedge CLK);
        #1;
        START = 1'b1;
        LINE = 10'd500;
        BANK = 1'b0;
        push_line(500, 1'b0, b1);
        @(posedge CLK);
        #1;
        LINE = 10'd777;
        BANK = 1'b1;
        push_line(777, 1'b1, b2);
        wait_done("b2b_first", 0);
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        chk("b2b_busy", BUSY, 1);
        chk("b2b_read_n", bus.DRAM_READ_N, 0);
        chk("b2b_addr", bus.DRAM_ADDRESS, b2);
        wait_done("b2b_second", 1);

        // Reset while reads are in flight; their late returns must be dropped.
        lat = 20; jit = 0; stall_pct = 0;
        @(posedge CLK);
        #1;
        START = 1'b1;
        LINE = 10'd37;
        BANK = 1'b0;
        push_line(37, 1'b0, b1);
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        gen++;
        flush_cnt++;
        @(negedge CLK);
        check_reset("mid_reset");
        n = 0;
        while (pend.size() > 0 && n < 200) begin
            @(negedge CLK);
            chk("stale_no_write", bus.OCM_WE, 0);
            chk("stale_idle_busy", BUSY, 0);
            n++;
        end
        chk("stale_returns_drained", pend.size(), 0);
        repeat (3) @(posedge CLK);
        lat = 2; jit = 1; stall_pct = 8;
        run_line("after_reset", 9, 1'b1, 1'b0);

        repeat (5) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
